// File: rtl/pebble_host_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pebble_host_if : run request/report and core-control bundle          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pebble_host_if #(
  parameter int CNT_W = 16
);
  logic             run_req;
  logic             run_busy;
  logic             core_reset;
  logic             core_start;
  logic             core_done;
  logic             run_valid;
  logic [CNT_W-1:0] run_cycles;
  logic             run_timeout;
  logic [7:0]       run_count;

  modport master (
    output run_req, core_done,
    input  run_busy, core_reset, core_start, run_valid, run_cycles, run_timeout, run_count
  );

  modport slave (
    input  run_req, core_done,
    output run_busy, core_reset, core_start, run_valid, run_cycles, run_timeout, run_count
  );
endinterface
`default_nettype wire

// File: rtl/pebble_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pebble_host : run sequencer (reset hold, start pulse, done/timeout)  |
// | Optional watchdog: define PEBBLE_HOST_WATCHDOG_EN      Rev 1.0        |
// +----------------------------------------------------------------------+
module pebble_host #(
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1000
) (
  input wire           clk,
  input wire           reset,
  pebble_host_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam logic [7:0]       RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [7:0]       rst_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             timeout_hit;

  assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

`ifdef PEBBLE_HOST_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
  assign timeout_hit = (cnt_next == TIMEOUT_VAL);
`else
  logic unused_timeout;
  assign unused_timeout = ^{1'b0, 32'(TIMEOUT)};
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      rst_cnt         <= '0;
      cnt             <= '0;
      bus.core_reset  <= 1'b1;
      bus.core_start  <= 1'b0;
      bus.run_busy    <= 1'b0;
      bus.run_valid   <= 1'b0;
      bus.run_cycles  <= '0;
      bus.run_timeout <= 1'b0;
      bus.run_count   <= '0;
    end else begin
      bus.run_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.run_req) begin
            state          <= S_RST;
            rst_cnt        <= '0;
            bus.core_reset <= 1'b1;
            bus.run_busy   <= 1'b1;
          end
        end
        S_RST: begin
          if (rst_cnt == RST_LAST) begin
            state          <= S_START;
            bus.core_reset <= 1'b0;
            bus.core_start <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 8'd1;
          end
        end
        S_START: begin
          state          <= S_RUN;
          cnt            <= '0;
          bus.core_start <= 1'b0;
        end
        S_RUN: begin
          cnt <= cnt_next;
          // done takes priority; on a timeout cnt_next equals TIMEOUT
          if (bus.core_done || timeout_hit) begin
            state           <= S_REPORT;
            bus.run_cycles  <= cnt_next;
            bus.run_timeout <= ~bus.core_done;
            bus.run_valid   <= 1'b1;
            bus.run_count   <= bus.run_count + 8'd1;
          end
        end
        S_REPORT: begin
          state          <= S_IDLE;
          bus.run_busy   <= 1'b0;
          bus.core_reset <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pebble_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pebble_host : directed bench with timeline model for pebble_host  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pebble_host;
  localparam int CNT_W = 8;
  localparam int R     = 2;
  localparam int TMO   = 20;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef PEBBLE_HOST_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   ok;

  pebble_host_if #(.CNT_W(CNT_W)) bus();

  pebble_host #(
    .CNT_W      (CNT_W),
    .RST_CYCLES (R),
    .TIMEOUT    (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (bus.run_valid) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_valid: got no run_valid within %0d cycles, required one", limit);
    end
  endtask

  task automatic wait_start(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (bus.core_start) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_start: got no core_start within %0d cycles, required one", limit);
    end
  endtask

  // Timeline model: rel counts cycles since acceptance (1 = first reset-hold cycle)
  bit m_act    = 1'b0;
  bit m_rep    = 1'b0;
  int m_rel    = 0;
  int m_count  = 0;
  int m_cycles = 0;
  bit m_to     = 1'b0;

  always @(posedge clk) begin : p_model
    int k;
    bit d;
    bit q;
    d = bus.core_done;
    q = bus.run_req;
    cyc++;
    if (reset) begin
      m_act = 0; m_rep = 0; m_rel = 0;
      m_count = 0; m_cycles = 0; m_to = 0;
    end else if (!m_act) begin
      m_rep = 0;
      if (q) begin
        m_act = 1;
        m_rel = 1;
      end
    end else if (m_rep) begin
      m_act = 0; m_rep = 0; m_rel = 0;
    end else begin
      k = m_rel - (R + 1);
      m_rel++;
      if (k >= 1 && (d || (WD && k == TMO))) begin
        m_rep    = 1;
        m_count  = (m_count + 1) % 256;
        m_cycles = d ? ((k > MAXC) ? MAXC : k) : TMO;
        m_to     = !d;
      end
    end
    #1;
    chk("m_core_reset",  bus.core_reset,  (!m_act || m_rel <= R));
    chk("m_core_start",  bus.core_start,  (m_act && !m_rep && m_rel == R + 1));
    chk("m_run_busy",    bus.run_busy,    m_act);
    chk("m_run_valid",   bus.run_valid,   m_rep);
    chk("m_run_cycles",  bus.run_cycles,  m_cycles);
    chk("m_run_timeout", bus.run_timeout, m_to);
    chk("m_run_count",   bus.run_count,   m_count);
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required end of test");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1;
    bus.run_req = 1'b0;
    bus.core_done = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_core_reset", bus.core_reset, 1);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_busy",       bus.run_busy,   0);
    chk("rst_valid",      bus.run_valid,  0);
    chk("rst_cycles",     bus.run_cycles, 0);
    chk("rst_count",      bus.run_count,  0);
    reset = 1'b0;
    tick();

    // basic run: request in cycle 0, done in 5th RUN cycle (cycle 8)
    bus.run_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) bus.run_req = 1'b0;
      if (c <= 2) chk("basic_reset_hold", bus.core_reset, 1);
      if (c == 3) begin
        chk("basic_start", bus.core_start, 1);
        chk("basic_start_rst", bus.core_reset, 0);
      end
      if (c == 8) chk("basic_no_early_valid", bus.run_valid, 0);
      if (c == 9) begin
        chk("basic_valid",   bus.run_valid,   1);
        chk("basic_cycles",  bus.run_cycles,  5);
        chk("basic_timeout", bus.run_timeout, 0);
        chk("basic_count",   bus.run_count,   1);
      end
      bus.core_done = (c == 8);
    end

    // immediate done: done high before and during RST/START
    bus.core_done = 1'b1;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    wait_valid(20, ok);
    chk("imm_cycles",  bus.run_cycles,  1);
    chk("imm_timeout", bus.run_timeout, 0);
    chk("imm_count",   bus.run_count,   2);
    bus.core_done = 1'b0;

    // busy-ignore: req pulse mid-RUN, then held across REPORT
    tick();
    tick();
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    wait_start(10);
    tick();
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    tick();
    bus.core_done = 1'b1;
    bus.run_req = 1'b1;
    tick();
    chk("busy_valid",  bus.run_valid,  1);
    chk("busy_cycles", bus.run_cycles, 3);
    chk("busy_count",  bus.run_count,  3);
    bus.core_done = 1'b0;
    tick();
    chk("busy_idle_gap", bus.run_busy, 0);
    tick();
    chk("busy_rst_again", bus.run_busy, 1);
    chk("busy_rst_hold",  bus.core_reset, 1);
    bus.run_req = 1'b0;
    bus.core_done = 1'b1;
    wait_valid(20, ok);
    chk("busy_count2", bus.run_count, 4);
    bus.core_done = 1'b0;

`ifdef PEBBLE_HOST_WATCHDOG_EN
    tick();
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    wait_valid(60, ok);
    chk("wd_timeout", bus.run_timeout, 1);
    chk("wd_cycles",  bus.run_cycles,  20);
    chk("wd_count",   bus.run_count,   5);
    tick();
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    wait_start(10);
    for (int k = 1; k <= 20; k++) begin
      tick();
      bus.core_done = (k == 20);
    end
    tick();
    chk("wd_tie_valid",   bus.run_valid,   1);
    chk("wd_tie_timeout", bus.run_timeout, 0);
    chk("wd_tie_cycles",  bus.run_cycles,  20);
    bus.core_done = 1'b0;
`else
    tick();
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    wait_start(10);
    repeat (300) tick();
    chk("sat_still_busy", bus.run_busy,  1);
    chk("sat_no_valid",   bus.run_valid, 0);
    bus.core_done = 1'b1;
    wait_valid(5, ok);
    chk("sat_cycles",  bus.run_cycles,  255);
    chk("sat_timeout", bus.run_timeout, 0);
    chk("sat_count",   bus.run_count,   5);
    bus.core_done = 1'b0;
`endif

    // reset asserted in the 3rd RUN cycle
    tick();
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    wait_start(10);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_core_reset", bus.core_reset, 1);
    chk("mid_rst_busy",       bus.run_busy,   0);
    chk("mid_rst_valid",      bus.run_valid,  0);
    chk("mid_rst_count",      bus.run_count,  0);
    chk("mid_rst_cycles",     bus.run_cycles, 0);
    tick();
    tick();
    reset = 1'b0;
    bus.core_done = 1'b1;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    wait_valid(20, ok);
    chk("fresh_count",  bus.run_count,  1);
    chk("fresh_cycles", bus.run_cycles, 1);

    // wrap: 256 back-to-back runs from a cleared count
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.run_req = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      wait_valid(20, ok);
      if (!ok) break;
      if (n == 255) chk("wrap_255", bus.run_count, 255);
      if (n == 256) chk("wrap_0",   bus.run_count, 0);
    end
    bus.run_req = 1'b0;
    bus.core_done = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pebble_host.md
# pebble_host

Run sequencer for the Pebble core; it drives the core's `reset`/`start` inputs and consumes its `done` output. On each run request it holds the core in reset, pulses start, and waits for done. It then reports the run length in clock cycles and whether the run ended by timeout. It sits between the bench or system controller and `TopLevel`, and provides a single request/report interface for back-to-back program executions.

## Interface
- `CNT_W`, 16: width of the cycle counter and `run_cycles`.
- `RST_CYCLES`, 2: number of cycles `core_reset` is held after a request; legal range 1..255.
- `TIMEOUT`, 1000: RUN-cycle limit before a run is aborted; legal range 1..2^CNT_W-1. Used only with the watchdog compiled in.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run_req`  in  1  request a run; sampled only in IDLE.
- `run_busy`  out  1  high from the cycle after acceptance through REPORT.
- `core_reset`  out  1  drives the core's `reset`.
- `core_start`  out  1  drives the core's `start`.
- `core_done`  in  1  the core's `done`.
- `run_valid`  out  1  one-cycle pulse when a run result is reported.
- `run_cycles`  out  CNT_W  length of the last run in RUN cycles.
- `run_timeout`  out  1  the last run ended by watchdog, not by done.
- `run_count`  out  8  number of completed runs (done or timeout); wraps 255→0.

## Operation
- States: IDLE, RST, START, RUN, REPORT. All outputs are registered.
- IDLE:
  - `core_reset`=1, `core_start`=0, `run_busy`=0.
  - `run_req`=1 → RST, with the reset-hold counter loaded to 0.
- RST:
  - `core_reset`=1, `run_busy`=1.
  - Stays for exactly RST_CYCLES cycles, then → START.
- START:
  - Lasts exactly one cycle: `core_reset`=0, `core_start`=1.
  - Then → RUN, with the cycle counter cleared to 0.
- RUN:
  - `core_start`=0, `core_reset`=0.
  - On every RUN cycle the next count is counter+1, saturating at all-ones.
  - If `core_done`=1: latch `run_cycles`=next count and `run_timeout`=0, then → REPORT.
  - Otherwise, with the watchdog enabled, if next count == TIMEOUT: latch `run_cycles`=TIMEOUT and `run_timeout`=1, then → REPORT.
- REPORT:
  - Lasts one cycle: `run_valid`=1, `run_count` increments, `run_busy`=1.
  - Then → IDLE.
- `core_done` is ignored in IDLE, RST, START and REPORT. A stale done from the previous program never ends a run.
- `run_req` is ignored outside IDLE; it is not queued.
- If `run_req` is held high continuously, runs repeat back-to-back, with one IDLE cycle between REPORT and the next RST.
- `run_cycles` and `run_timeout` hold their values until the next REPORT.

## Timing
- Reset values (asserted asynchronously, for the whole time `reset` is high):
  - state IDLE, `core_reset`=1, `core_start`=0, `run_busy`=0.
  - `run_valid`=0, `run_cycles`=0, `run_timeout`=0, `run_count`=0.
- Request accepted at edge t (IDLE, `run_req`=1):
  - `core_reset` stays high for cycles t+1..t+RST_CYCLES.
  - `core_start`=1 in cycle t+RST_CYCLES+1.
  - The first RUN cycle is t+RST_CYCLES+2.
- If `core_done` is first high in the k-th RUN cycle:
  - `run_valid` pulses in the next cycle, with `run_cycles`=k.
  - Latency from the done cycle to `run_valid` is 1 cycle.
- Done and timeout in the same cycle: done wins (`run_timeout`=0, `run_cycles`=TIMEOUT).
- Counter saturation applies only with the watchdog disabled.
- `reset` asserted mid-run:
  - The run is discarded immediately; no `run_valid` is produced.
  - `run_count` clears, and the core is re-held in reset via `core_reset`=1.
- After `reset` deasserts, the first possible acceptance is the first rising edge with `run_req`=1.

## Configuration
- `PEBBLE_HOST_WATCHDOG_EN` defined:
  - The TIMEOUT comparison is built.
  - A run that never asserts done ends after TIMEOUT RUN cycles with `run_timeout`=1.
- Not defined:
  - No comparator is built and `run_timeout` is constant 0.
  - RUN waits indefinitely for `core_done`; `run_cycles` saturates at 2^CNT_W-1.
  - The TIMEOUT parameter is unused.

## Test plan
- Basic run (RST_CYCLES=2): pulse `run_req` at cycle 0; `core_done` rises in the 5th RUN cycle.
  - Required: `core_reset` high cycles 1-2, `core_start` high cycle 3.
  - Required: `run_valid` at cycle 9 with `run_cycles`=5, `run_timeout`=0, `run_count`=1.
- Immediate done: `core_done` held high throughout, including RST and START.
  - Required: RST and START are unaffected; `run_cycles`=1.
- Watchdog (macro defined, TIMEOUT=20): `core_done` never asserts.
  - Required: `run_valid` with `run_timeout`=1, `run_cycles`=20.
  - Second case: done first high on the 20th RUN cycle → `run_timeout`=0, `run_cycles`=20.
- Busy-ignore: pulse `run_req` during RUN, then hold it high across REPORT.
  - Required: no extra run from the mid-RUN pulse.
  - Required: the next RST starts exactly 2 cycles after REPORT (one IDLE cycle); `run_count` increments once per REPORT.
- Reset mid-run: assert `reset` in the 3rd RUN cycle.
  - Required: outputs go to their reset values that same cycle, with no `run_valid`.
  - Required: `run_count`=0, then a fresh run completes normally.
- Wrap: complete 256 runs.
  - Required: `run_count` returns to 0 on the 256th REPORT.
